// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory load/store arbiter.
package dmem_pkg;

    // Access size field on both request ports
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    // Memory store-mode field
    localparam logic [1:0] ST_B = 2'b00;
    localparam logic [1:0] ST_H = 2'b01;
    localparam logic [1:0] ST_W = 2'b10;

    typedef enum logic {
        PORT_C = 1'b0,
        PORT_D = 1'b1
    } port_t;

    // Number of bytes touched by an access; the illegal size is rejected
    // separately, so its byte count only has to keep the range check sane.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_B:    size_bytes = 3'd1;
            SZ_H:    size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dmem_arb_lsu_load_ext.sv
// Load-data extraction: picks the low byte/half/word of the memory read
// and sign- or zero-extends it to the full data width.
module load_ext
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int BYTE_W = 8
) (
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        size,
    input  logic              uns,
    output logic [DATA_W-1:0] ext
);

    // Extension fill bit is the top bit of the selected field unless unsigned
    always_comb begin
        ext = data;
        case (size)
            SZ_B:    ext = {{(DATA_W-BYTE_W){~uns & data[BYTE_W-1]}}, data[BYTE_W-1:0]};
            SZ_H:    ext = {{(DATA_W-2*BYTE_W){~uns & data[2*BYTE_W-1]}}, data[2*BYTE_W-1:0]};
            default: ext = data;
        endcase
    end

endmodule

// File: rtl/dmem_arb_lsu.sv
// Two-port (CPU / debug) round-robin arbiter and load/store sequencer in
// front of a byte-addressed data memory. One access per cycle; response is
// registered and appears the cycle after the grant.
module dmem_arb_lsu
    import dmem_pkg::*;
#(
    parameter int PC_WIDTH = 32,
    parameter int DATA_W   = 32,
    parameter int STORE_M  = 2,
    parameter int M_STACK  = 1024,
    parameter int BYTE_W   = 8
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                c_req,
    input  logic                c_we,
    input  logic [PC_WIDTH-1:0] c_addr,
    input  logic [1:0]          c_size,
    input  logic                c_uns,
    input  logic [DATA_W-1:0]   c_wdata,
    output logic                c_gnt,
    output logic                c_rvalid,
    output logic [DATA_W-1:0]   c_rdata,
    output logic                c_err,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [PC_WIDTH-1:0] d_addr,
    input  logic [1:0]          d_size,
    input  logic                d_uns,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_err,
    output logic                mem_wr_en,
    output logic [PC_WIDTH-1:0] mem_rd_addr,
    output logic [PC_WIDTH-1:0] mem_wr_addr,
    output logic [STORE_M-1:0]  mem_mode,
    output logic [DATA_W-1:0]   mem_d_in,
    input  logic [DATA_W-1:0]   mem_d_out
);

    port_t               rr_last;
    logic                sel_we;
    logic [PC_WIDTH-1:0] sel_addr;
    logic [1:0]          sel_size;
    logic                sel_uns;
    logic [DATA_W-1:0]   sel_wdata;
    logic [PC_WIDTH:0]   end_addr;
    logic                err_now;
    logic                st_ok;
    logic                ld_ok;
    logic [DATA_W-1:0]   ld_data;

    // Round-robin grant; nothing is granted while reset is held
    always_comb begin
        c_gnt = 1'b0;
        d_gnt = 1'b0;
        if (n_rst) begin
            if (c_req && (!d_req || rr_last == PORT_D)) c_gnt = 1'b1;
            else if (d_req)                             d_gnt = 1'b1;
        end
    end

    // Request mux, alignment/range checks and memory-side drive
    always_comb begin
        sel_we    = d_gnt ? d_we    : c_we;
        sel_addr  = d_gnt ? d_addr  : c_addr;
        sel_size  = d_gnt ? d_size  : c_size;
        sel_uns   = d_gnt ? d_uns   : c_uns;
        sel_wdata = d_gnt ? d_wdata : c_wdata;

        // One extra bit so an access near the top of the address space
        // cannot wrap past the range check.
        end_addr = {1'b0, sel_addr} + {{(PC_WIDTH-2){1'b0}}, size_bytes(sel_size)};

        err_now = 1'b0;
        if (sel_size == SZ_X)                               err_now = 1'b1;
        if (sel_size == SZ_H && sel_addr[0])                err_now = 1'b1;
        if (sel_size == SZ_W && sel_addr[1:0] != 2'b00)     err_now = 1'b1;
        if (end_addr > (PC_WIDTH+1)'(M_STACK))              err_now = 1'b1;

        st_ok = (c_gnt | d_gnt) &  sel_we & ~err_now;
        ld_ok = (c_gnt | d_gnt) & ~sel_we & ~err_now;

        mem_wr_en   = st_ok;
        mem_wr_addr = st_ok ? sel_addr  : '0;
        mem_mode    = st_ok ? STORE_M'(sel_size) : '0;
        mem_d_in    = st_ok ? sel_wdata : '0;
        mem_rd_addr = ld_ok ? sel_addr  : '0;
    end

    load_ext #(
        .DATA_W (DATA_W),
        .BYTE_W (BYTE_W)
    ) u_load_ext (
        .data (mem_d_out),
        .size (sel_size),
        .uns  (sel_uns),
        .ext  (ld_data)
    );

    // Registered responses and round-robin history
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            rr_last  <= PORT_D;
            c_rvalid <= 1'b0;
            c_err    <= 1'b0;
            c_rdata  <= '0;
            d_rvalid <= 1'b0;
            d_err    <= 1'b0;
            d_rdata  <= '0;
        end else begin
            c_rvalid <= c_gnt;
            c_err    <= c_gnt & err_now;
            c_rdata  <= (c_gnt && ld_ok) ? ld_data : '0;
            d_rvalid <= d_gnt;
            d_err    <= d_gnt & err_now;
            d_rdata  <= (d_gnt && ld_ok) ? ld_data : '0;
            if (c_gnt)      rr_last <= PORT_C;
            else if (d_gnt) rr_last <= PORT_D;
        end
    end

endmodule
